// File: rtl/mhp_pkg.sv
// mhp_pkg -- shared definitions for the MHP frame transmit/receive datapath.
//   state_t         : frame sequencing states (IDLE, HDR, PAYLOAD, SCS_HI, SCS_LO)
//   MHP_HDR_LEN     : header byte count (DST 2, SRC 2, SIZE 2, DTYPE 1)
//   OFF_*           : byte offsets of each header field within the frame
//   scs_term()      : one checksum term, byte shifted left by (index mod 4)
package mhp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_SCS_HI  = 3'd3,
    ST_SCS_LO  = 3'd4
  } state_t;

  localparam int MHP_HDR_LEN = 7;

  localparam logic [2:0] OFF_DST_HI  = 3'd0;
  localparam logic [2:0] OFF_DST_LO  = 3'd1;
  localparam logic [2:0] OFF_SRC_HI  = 3'd2;
  localparam logic [2:0] OFF_SRC_LO  = 3'd3;
  localparam logic [2:0] OFF_SIZE_HI = 3'd4;
  localparam logic [2:0] OFF_SIZE_LO = 3'd5;
  localparam logic [2:0] OFF_DTYPE   = 3'd6;

  // Byte zero-extended to 16 bits, shifted by the low two bits of its frame index.
  function automatic logic [15:0] scs_term(input logic [7:0] i_byte, input logic [1:0] i_k);
    return {8'h00, i_byte} << i_k;
  endfunction

endpackage

// File: rtl/mhp_scs.sv
// mhp_scs -- running MHP checksum accumulator (shared by transmit and receive).
//   i_clk, i_rst : clock, asynchronous active-high reset (sum -> 0)
//   i_clr        : restart the sum; if i_add is also high the first term is loaded
//   i_add        : accumulate scs_term(i_byte, i_k) this cycle
//   i_byte       : frame byte
//   i_k          : frame byte index, low two bits
//   o_sum        : 16-bit sum modulo 2^16
module mhp_scs
  import mhp_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_add,
  input  logic [7:0]  i_byte,
  input  logic [1:0]  i_k,
  output logic [15:0] o_sum
);

  logic [15:0] r_sum;
  logic [15:0] w_term;

  assign w_term = scs_term(i_byte, i_k);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum <= '0;
    end else if (i_clr) begin
      // Clear and first add may coincide when byte 0 is loaded at start acceptance.
      r_sum <= i_add ? w_term : 16'h0000;
    end else if (i_add) begin
      r_sum <= r_sum + w_term;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/mhp_tx.sv
// mhp_tx -- MHP frame transmitter: header, payload stream, 16-bit SCS trailer.
//   i_clk, i_rst              : clock, asynchronous active-high reset
//   i_start                   : send one frame (accepted only when idle)
//   i_dst, i_src, i_size      : header fields captured at start acceptance
//   i_dtype                   : {dir, type[6:0]} header byte
//   i_pdata/i_pvalid/o_pready : payload byte stream in
//   o_wdata/o_wvalid/i_wready : frame byte stream out (single output register)
//   o_busy                    : frame in progress
//   o_done                    : pulse when the last SCS byte is accepted
//   o_err                     : pulse after a start with i_size > MAX_SIZE
module mhp_tx
  import mhp_pkg::*;
#(
  parameter int MAX_SIZE = 1024,
  parameter int HDR_LEN  = MHP_HDR_LEN
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_dst,
  input  logic [15:0] i_src,
  input  logic [15:0] i_size,
  input  logic [7:0]  i_dtype,
  input  logic [7:0]  i_pdata,
  input  logic        i_pvalid,
  output logic        o_pready,
  output logic [7:0]  o_wdata,
  output logic        o_wvalid,
  input  logic        i_wready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [16:0] LP_MAX      = 17'(MAX_SIZE);
  localparam logic [16:0] LP_HDR_LAST = 17'(HDR_LEN - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_dst, r_src, r_size;
  logic [7:0]  r_dtype;
  logic [16:0] r_idx, w_idx_nxt;
  logic [7:0]  r_wdata, w_byte;
  logic        r_wvalid, r_last, r_err;
  logic        w_free, w_load, w_add, w_clr, w_cap, w_err, w_done, w_pready, w_set_last;
  logic [1:0]  w_k;
  logic [15:0] w_sum;
  logic [7:0]  w_hdr_byte;
  logic [16:0] w_end;
  logic        w_oversize;

  // Output register can take a new byte when empty or being drained this cycle.
  assign w_free     = !r_wvalid || i_wready;
  assign w_end      = 17'(HDR_LEN) + {1'b0, r_size};
  assign w_oversize = {1'b0, i_size} > LP_MAX;

  always_comb begin
    w_hdr_byte = 8'h00;
    case (r_idx[2:0])
      OFF_DST_HI:  w_hdr_byte = r_dst[15:8];
      OFF_DST_LO:  w_hdr_byte = r_dst[7:0];
      OFF_SRC_HI:  w_hdr_byte = r_src[15:8];
      OFF_SRC_LO:  w_hdr_byte = r_src[7:0];
      OFF_SIZE_HI: w_hdr_byte = r_size[15:8];
      OFF_SIZE_LO: w_hdr_byte = r_size[7:0];
      OFF_DTYPE:   w_hdr_byte = r_dtype;
      default:     w_hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Each state names the kind of byte to be loaded next into the output register.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_add       = 1'b0;
    w_byte      = 8'h00;
    w_clr       = 1'b0;
    w_cap       = 1'b0;
    w_err       = 1'b0;
    w_done      = 1'b0;
    w_pready    = 1'b0;
    w_set_last  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (w_oversize) begin
            w_err = 1'b1;
          end else begin
            // First header byte comes straight from the inputs for latency 1.
            w_cap       = 1'b1;
            w_clr       = 1'b1;
            w_load      = 1'b1;
            w_add       = 1'b1;
            w_byte      = i_dst[15:8];
            w_idx_nxt   = 17'd1;
            w_state_nxt = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        if (w_free) begin
          w_load    = 1'b1;
          w_add     = 1'b1;
          w_byte    = w_hdr_byte;
          w_idx_nxt = r_idx + 17'd1;
          if (r_idx == LP_HDR_LAST)
            w_state_nxt = (r_size == 16'h0000) ? ST_SCS_HI : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        w_pready = w_free && (r_idx < w_end);
        if (w_pready && i_pvalid) begin
          w_load    = 1'b1;
          w_add     = 1'b1;
          w_byte    = i_pdata;
          w_idx_nxt = r_idx + 17'd1;
          if (r_idx == w_end - 17'd1) w_state_nxt = ST_SCS_HI;
        end
      end
      ST_SCS_HI: begin
        // The final payload/header term was added on the edge that loaded it.
        if (w_free) begin
          w_load      = 1'b1;
          w_byte      = w_sum[15:8];
          w_state_nxt = ST_SCS_LO;
        end
      end
      ST_SCS_LO: begin
        if (!r_last) begin
          if (w_free) begin
            w_load     = 1'b1;
            w_byte     = w_sum[7:0];
            w_set_last = 1'b1;
          end
        end else if (i_wready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx    <= '0;
      r_wdata  <= '0;
      r_wvalid <= 1'b0;
      r_last   <= 1'b0;
      r_err    <= 1'b0;
      r_dst    <= '0;
      r_src    <= '0;
      r_size   <= '0;
      r_dtype  <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      r_err <= w_err;
      if (w_load) begin
        r_wdata  <= w_byte;
        r_wvalid <= 1'b1;
      end else if (i_wready) begin
        r_wvalid <= 1'b0;
      end
      if (w_set_last)  r_last <= 1'b1;
      else if (w_done) r_last <= 1'b0;
      if (w_cap) begin
        r_dst   <= i_dst;
        r_src   <= i_src;
        r_size  <= i_size;
        r_dtype <= i_dtype;
      end
    end
  end

  assign w_k = w_cap ? 2'd0 : r_idx[1:0];

  mhp_scs u_scs (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_clr),
    .i_add  (w_add),
    .i_byte (w_byte),
    .i_k    (w_k),
    .o_sum  (w_sum)
  );

  assign o_wdata  = r_wdata;
  assign o_wvalid = r_wvalid;
  assign o_pready = w_pready;
  assign o_done   = w_done;
  assign o_err    = r_err;
  assign o_busy   = (r_state != ST_IDLE) && !w_done;

endmodule
